bp_weight_ghr_tables: RTL and testbench
=======================================

Name: bp_weight_ghr_tables

Overview:
Parametrised successor of the perceptron branch-predictor state block. Holds the pending-branch counter, the speculative global history register (GHR) and the weight table. Adds synchronous reset, a post-reset table-clear FSM, saturating per-weight training, a registered read port, and masked multi-entry history push and mispredict recovery. Sits between the fetch-side predictor datapath and the branch-resolve logic.

Parameters:
ROWS, 228, weight-table rows
WPR, 9, weights per row (bias plus history taps)
WEIGHT_W, 8, signed weight width
GHR_DEPTH, 20, GHR entries
ENTRY_W, 33, bits per GHR entry; bit 0 is the direction
MAX_PUSH, 4, max GHR entries pushed per cycle
CW, 8, pending-counter width

Ports:
fire  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_issueNum  in  CW  branches issued this cycle
i_resolveNum  in  CW  branches resolved this cycle
i_pushNum  in  clog2(MAX_PUSH+1)  GHR entries to push (0 = none)
i_pushEntries  in  MAX_PUSH*ENTRY_W  slot j becomes GHR position j (slot 0 youngest)
i_flush  in  1  mispredict recovery strobe
i_flushDepth  in  clog2(GHR_DEPTH)  younger entries to discard
i_trainValid  in  1  train one row
i_trainRow  in  clog2(ROWS)  row to train
i_trainDir  in  WPR  per-weight direction: 1 = +1, 0 = -1
i_trainMask  in  WPR  per-weight enable
i_rdValid  in  1  read request
i_rdRow  in  clog2(ROWS)  row to read
o_rdValid  out  1  read data valid
o_rdWeights  out  WPR*WEIGHT_W  row weights; weight k at [k*WEIGHT_W +: WEIGHT_W]
o_ready  out  1  table usable
o_pendingB  out  CW  branches in flight
o_ghr  out  GHR_DEPTH*ENTRY_W  history; entry 0 in the low bits is the youngest

Behaviour:
- Clocking: single clock on fire; reset is synchronous and active-high on i_rst. All state updates occur on the rising edge of fire.
- Reset values: o_pendingB=0, o_ghr=0, o_rdValid=0, o_rdWeights=0, o_ready=0, FSM in INIT with row counter at 0.
- FSM INIT: writes one all-zero row per cycle, rows 0 to ROWS-1. Train and read inputs are ignored, and o_rdValid stays 0. On the cycle after row ROWS-1 is written, FSM moves to RUN and o_ready=1. INIT lasts exactly ROWS cycles.
- FSM RUN: stays in RUN until the next reset. Reset asserted in any state returns to INIT at row 0.
- GHR and the pending counter operate in both states.
- Pending counter, no flush: next = pending + issue - resolve, saturating at 0 and 2^CW-1.
- Pending counter, flush cycle: next = pending - i_flushDepth - resolve, saturating at 0. i_issueNum is ignored.
- GHR push (no flush): GHR shifts left by i_pushNum entries and drops the oldest. Slots j < i_pushNum load position j. Slots j >= i_pushNum are masked and have no effect. i_pushNum > MAX_PUSH is clamped to MAX_PUSH.
- GHR flush: GHR shifts right by i_flushDepth entries with zero fill at the oldest end, then bit 0 of the new entry 0 is inverted. i_flushDepth=0 inverts only.
- Flush has priority over push in the same cycle; the push is dropped.
- Training (RUN, i_trainValid=1): each weight k with mask bit 1 becomes w+1 or w-1 per i_trainDir[k]. Results saturate to the symmetric range ±(2^(WEIGHT_W-1)-1), so -128 is never produced at W=8. Masked-off weights are unchanged. Write takes effect at the clock edge.
- Training is independent of flush: a train on a flush cycle still commits.
- Read: one-cycle latency. o_rdValid(t+1) = i_rdValid(t) in RUN. o_rdWeights holds its value while o_rdValid=0.
- Same-row read and train in one cycle: the read returns the pre-train value (read-before-write), unless the optional feature is enabled.

Optional Feature:
Macro BP_TABLE_BYPASS_EN.
- Defined: a read of the row being trained in the same cycle returns the post-train, saturated value. A read of the row being cleared in INIT is not possible because reads are ignored in INIT.
- Undefined: read-before-write as stated above. The forwarding mux is not built.

Test Plan:
- Reset, then hold idle -> o_ready=0 for 228 cycles then 1. Reading rows 0, 113 and 227 returns all zeros with o_rdValid one cycle after the request.
- Train row 5 with dir=all-1s and mask=all-1s, 130 times -> every weight reads 127. Then train dir=all-0s 300 times -> every weight reads -127.
- Push 3 entries A,B,C in slots 0..2 with i_pushNum=3 onto an empty GHR, then push D with i_pushNum=1 -> o_ghr entries 0..3 = D,A,B,C. Slot data beyond i_pushNum is ignored.
- From that GHR, flush with i_flushDepth=1 -> entries 0..2 = A',B,C where A' is A with bit 0 inverted. Entry 3 = 0. A push on the same cycle is ignored.
- Pending=3, issue=2, resolve=1 -> 4. Then flush with depth=2 and resolve=5 -> 0 (saturated). Pending=255 with issue=1 -> stays 255.
- Same-cycle read and train of row 9 (weights 0, dir +1) -> reads 0 without the macro, 1 with BP_TABLE_BYPASS_EN. Reset asserted mid-INIT at row 100 -> INIT restarts at row 0 and o_ready rises 228 cycles later.

Source files
------------

// File: rtl/bp_weight_ghr_tables.sv
// bp_weight_ghr_tables: perceptron weight table with clear FSM, saturating training, speculative GHR and pending-branch counter.
// Optional BP_TABLE_BYPASS_EN forwards a same-cycle trained row to the read port.
module bp_weight_ghr_tables #(
  parameter int ROWS      = 228,
  parameter int WPR       = 9,
  parameter int WEIGHT_W  = 8,
  parameter int GHR_DEPTH = 20,
  parameter int ENTRY_W   = 33,
  parameter int MAX_PUSH  = 4,
  parameter int CW        = 8
) (
  input  logic                               fire,
  input  logic                               i_rst,
  input  logic [CW-1:0]                      i_issueNum,
  input  logic [CW-1:0]                      i_resolveNum,
  input  logic [$clog2(MAX_PUSH+1)-1:0]      i_pushNum,
  input  logic [MAX_PUSH*ENTRY_W-1:0]        i_pushEntries,
  input  logic                               i_flush,
  input  logic [$clog2(GHR_DEPTH)-1:0]       i_flushDepth,
  input  logic                               i_trainValid,
  input  logic [$clog2(ROWS)-1:0]            i_trainRow,
  input  logic [WPR-1:0]                     i_trainDir,
  input  logic [WPR-1:0]                     i_trainMask,
  input  logic                               i_rdValid,
  input  logic [$clog2(ROWS)-1:0]            i_rdRow,
  output logic                               o_rdValid,
  output logic [WPR*WEIGHT_W-1:0]            o_rdWeights,
  output logic                               o_ready,
  output logic [CW-1:0]                      o_pendingB,
  output logic [GHR_DEPTH*ENTRY_W-1:0]       o_ghr
);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(MAX_PUSH+1);
  localparam int GW = GHR_DEPTH*ENTRY_W;
  localparam int TW = WPR*WEIGHT_W;
  localparam logic [WEIGHT_W-1:0] WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] WMIN = {1'b1, {(WEIGHT_W-2){1'b0}}, 1'b1};
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [TW-1:0] tbl_q [ROWS];
  logic [TW-1:0] cur_w, trn_w, rd_w, rd_w_q;
  logic rd_valid_q;
  logic [GW-1:0] ghr_q, ghr_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [CW:0] up, dn, diff;
  logic [PW-1:0] npush;
  logic [MAX_PUSH*ENTRY_W-1:0] pmask;
  assign o_ready = state_q == RUN;
  assign o_rdValid = rd_valid_q;
  assign o_rdWeights = rd_w_q;
  assign o_pendingB = pend_q;
  assign o_ghr = ghr_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    if (state_q == INIT) begin
      row_d = row_q + 1'b1;
      if (row_q == RW'(ROWS-1)) begin
        state_d = RUN;
        row_d = '0;
      end
    end
  end
  assign cur_w = tbl_q[i_trainRow];
  // Symmetric saturation keeps the most negative code unused.
  for (genvar k = 0; k < WPR; k++) begin : g_sat
    logic [WEIGHT_W-1:0] w;
    assign w = cur_w[k*WEIGHT_W +: WEIGHT_W];
    assign trn_w[k*WEIGHT_W +: WEIGHT_W] = !i_trainMask[k] ? w :
      i_trainDir[k] ? (w == WMAX ? w : w + 1'b1) : (w == WMIN ? w : w - 1'b1);
  end
`ifdef BP_TABLE_BYPASS_EN
  assign rd_w = (i_trainValid && i_trainRow == i_rdRow) ? trn_w : tbl_q[i_rdRow];
`else
  assign rd_w = tbl_q[i_rdRow];
`endif
  always_ff @(posedge fire) begin
    if (state_q == INIT) tbl_q[row_q] <= '0;
    else if (i_trainValid) tbl_q[i_trainRow] <= trn_w;
  end
  assign up = {1'b0, pend_q} + (i_flush ? '0 : {1'b0, i_issueNum});
  assign dn = {1'b0, i_resolveNum} + (i_flush ? (CW+1)'(i_flushDepth) : '0);
  assign diff = up - dn;
  assign pend_d = dn > up ? '0 : diff[CW] ? '1 : diff[CW-1:0];
  assign npush = i_pushNum > PW'(MAX_PUSH) ? PW'(MAX_PUSH) : i_pushNum;
  assign pmask = ~({(MAX_PUSH*ENTRY_W){1'b1}} << (npush*ENTRY_W));
  // Flush wins over push; the recovered youngest entry gets its direction flipped.
  always_comb begin
    ghr_d = i_flush ? ghr_q >> (i_flushDepth*ENTRY_W)
                    : (ghr_q << (npush*ENTRY_W)) | GW'(i_pushEntries & pmask);
    ghr_d[0] = ghr_d[0] ^ i_flush;
  end
  always_ff @(posedge fire) begin
    if (i_rst) begin
      state_q <= INIT;
      row_q <= '0;
      pend_q <= '0;
      ghr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_w_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      pend_q <= pend_d;
      ghr_q <= ghr_d;
      rd_valid_q <= o_ready && i_rdValid;
      if (o_ready && i_rdValid) rd_w_q <= rd_w;
    end
  end
endmodule

// File: tb/tb_bp_weight_ghr_tables.sv
// tb_bp_weight_ghr_tables: directed and random checks of bp_weight_ghr_tables against a queue/array reference model.
module tb_bp_weight_ghr_tables;
  localparam int ROWS = 228, WPR = 9, WW = 8, GD = 20, EW = 33, MP = 4, CW = 8;
  localparam int RW = $clog2(ROWS), PW = $clog2(MP+1), FW = $clog2(GD);
  logic fire = 1'b0;
  always #5 fire = ~fire;
  logic i_rst, i_flush, i_trainValid, i_rdValid;
  logic [CW-1:0] i_issueNum, i_resolveNum;
  logic [PW-1:0] i_pushNum;
  logic [MP*EW-1:0] i_pushEntries;
  logic [FW-1:0] i_flushDepth;
  logic [RW-1:0] i_trainRow, i_rdRow;
  logic [WPR-1:0] i_trainDir, i_trainMask;
  logic o_rdValid, o_ready;
  logic [WPR*WW-1:0] o_rdWeights;
  logic [CW-1:0] o_pendingB;
  logic [GD*EW-1:0] o_ghr;
  bp_weight_ghr_tables #(.ROWS(ROWS), .WPR(WPR), .WEIGHT_W(WW), .GHR_DEPTH(GD),
    .ENTRY_W(EW), .MAX_PUSH(MP), .CW(CW)) dut (
    .fire(fire), .i_rst(i_rst), .i_issueNum(i_issueNum), .i_resolveNum(i_resolveNum),
    .i_pushNum(i_pushNum), .i_pushEntries(i_pushEntries), .i_flush(i_flush),
    .i_flushDepth(i_flushDepth), .i_trainValid(i_trainValid), .i_trainRow(i_trainRow),
    .i_trainDir(i_trainDir), .i_trainMask(i_trainMask), .i_rdValid(i_rdValid),
    .i_rdRow(i_rdRow), .o_rdValid(o_rdValid), .o_rdWeights(o_rdWeights),
    .o_ready(o_ready), .o_pendingB(o_pendingB), .o_ghr(o_ghr));
  int w [ROWS][WPR];
  int pend, init_left;
  logic [EW-1:0] g [$];
  logic exp_rdv;
  logic [WPR*WW-1:0] exp_rdw;
  int n_assert = 0, n_fail = 0;
  logic [EW-1:0] ea = 33'h1_0000_00A1, eb = 33'h0_1234_5678, ec = 33'h1_DEAD_BEEF, ed = 33'h0_0F0F_0F0E;
  function automatic logic [WPR*WW-1:0] row_bits(int r);
    logic [WPR*WW-1:0] v;
    for (int k = 0; k < WPR; k++) v[k*WW +: WW] = WW'(w[r][k]);
    return v;
  endfunction
  task automatic train_model();
    for (int k = 0; k < WPR; k++)
      if (i_trainMask[k]) begin
        if (i_trainDir[k]) w[i_trainRow][k] = (w[i_trainRow][k] >= 127) ? 127 : w[i_trainRow][k] + 1;
        else w[i_trainRow][k] = (w[i_trainRow][k] <= -127) ? -127 : w[i_trainRow][k] - 1;
      end
  endtask
  task automatic idle();
    i_issueNum = '0; i_resolveNum = '0; i_pushNum = '0; i_pushEntries = '0;
    i_flush = 1'b0; i_flushDepth = '0; i_trainValid = 1'b0; i_trainRow = '0;
    i_trainDir = '0; i_trainMask = '0; i_rdValid = 1'b0; i_rdRow = '0;
  endtask
  task automatic cyc();
    logic [GD*EW-1:0] exp_g;
    logic [EW-1:0] e;
    int n;
    if (i_rst) begin
      pend = 0; init_left = ROWS; exp_rdv = 1'b0; exp_rdw = '0;
      g.delete();
      repeat (GD) g.push_back('0);
      foreach (w[r, k]) w[r][k] = 0;
    end else begin
      if (init_left == 0) begin
`ifdef BP_TABLE_BYPASS_EN
        if (i_trainValid) train_model();
        if (i_rdValid) exp_rdw = row_bits(int'(i_rdRow));
`else
        if (i_rdValid) exp_rdw = row_bits(int'(i_rdRow));
        if (i_trainValid) train_model();
`endif
        exp_rdv = i_rdValid;
      end else begin
        exp_rdv = 1'b0;
        init_left--;
      end
      if (i_flush) begin
        pend = pend - int'(i_flushDepth) - int'(i_resolveNum);
        if (pend < 0) pend = 0;
        repeat (int'(i_flushDepth)) begin
          void'(g.pop_front());
          g.push_back('0);
        end
        e = g[0]; e[0] = ~e[0]; g[0] = e;
      end else begin
        pend = pend + int'(i_issueNum) - int'(i_resolveNum);
        if (pend < 0) pend = 0;
        if (pend > 255) pend = 255;
        n = (int'(i_pushNum) > MP) ? MP : int'(i_pushNum);
        for (int j = n - 1; j >= 0; j--) g.push_front(i_pushEntries[j*EW +: EW]);
        while (g.size() > GD) void'(g.pop_back());
      end
    end
    for (int i = 0; i < GD; i++) exp_g[i*EW +: EW] = g[i];
    @(posedge fire);
    #1;
    n_assert++;
    assert (o_ready === (init_left == 0)) else begin n_fail++; $error("FAIL ready: got %b expected %b", o_ready, init_left == 0); end
    n_assert++;
    assert (o_pendingB === CW'(pend)) else begin n_fail++; $error("FAIL pending: got %0d expected %0d", o_pendingB, pend); end
    n_assert++;
    assert (o_ghr === exp_g) else begin n_fail++; $error("FAIL ghr: got %h expected %h", o_ghr, exp_g); end
    n_assert++;
    assert (o_rdValid === exp_rdv) else begin n_fail++; $error("FAIL rdValid: got %b expected %b", o_rdValid, exp_rdv); end
    n_assert++;
    assert (o_rdWeights === exp_rdw) else begin n_fail++; $error("FAIL rdWeights: got %h expected %h", o_rdWeights, exp_rdw); end
  endtask
  initial begin
    idle();
    i_rst = 1'b1;
    cyc();
    cyc();
    i_rst = 1'b0;
    i_rdValid = 1'b1; i_trainValid = 1'b1; i_trainMask = '1; i_trainDir = '1;
    repeat (ROWS) cyc();
    idle();
    n_assert++;
    assert (o_ready === 1'b1) else begin n_fail++; $error("FAIL init_len: got %b expected 1", o_ready); end
    foreach (ea[i]) ;
    for (int r = 0; r < 3; r++) begin
      i_rdValid = 1'b1; i_rdRow = RW'(r == 0 ? 0 : r == 1 ? 113 : 227);
      cyc();
      n_assert++;
      assert (o_rdValid === 1'b1 && o_rdWeights === '0) else begin n_fail++; $error("FAIL clear_read: got %b/%h expected 1/0", o_rdValid, o_rdWeights); end
      i_rdValid = 1'b0;
      cyc();
    end
    i_trainValid = 1'b1; i_trainRow = 5; i_trainDir = '1; i_trainMask = '1;
    repeat (130) cyc();
    idle(); i_rdValid = 1'b1; i_rdRow = 5;
    cyc();
    n_assert++;
    assert (o_rdWeights === {WPR{8'h7f}}) else begin n_fail++; $error("FAIL sat_pos: got %h expected all 7f", o_rdWeights); end
    idle(); i_trainValid = 1'b1; i_trainRow = 5; i_trainDir = '0; i_trainMask = '1;
    repeat (300) cyc();
    idle(); i_rdValid = 1'b1; i_rdRow = 5;
    cyc();
    n_assert++;
    assert (o_rdWeights === {WPR{8'h81}}) else begin n_fail++; $error("FAIL sat_neg: got %h expected all 81", o_rdWeights); end
    idle(); i_trainValid = 1'b1; i_trainRow = 9; i_trainDir = '1; i_trainMask = '1; i_rdValid = 1'b1; i_rdRow = 9;
    cyc();
    n_assert++;
`ifdef BP_TABLE_BYPASS_EN
    assert (o_rdWeights === {WPR{8'h01}}) else begin n_fail++; $error("FAIL rw_same_row: got %h expected all 01", o_rdWeights); end
`else
    assert (o_rdWeights === '0) else begin n_fail++; $error("FAIL rw_same_row: got %h expected 0", o_rdWeights); end
`endif
    idle(); i_pushNum = 3; i_pushEntries = {EW'({$urandom, $urandom}), ec, eb, ea};
    cyc();
    i_pushNum = 1; i_pushEntries = {EW'({$urandom, $urandom}), EW'({$urandom, $urandom}), EW'({$urandom, $urandom}), ed};
    cyc();
    n_assert++;
    assert (o_ghr[4*EW-1:0] === {ec, eb, ea, ed}) else begin n_fail++; $error("FAIL ghr_push: got %h expected %h", o_ghr[4*EW-1:0], {ec, eb, ea, ed}); end
    i_pushNum = 2; i_flush = 1'b1; i_flushDepth = 1;
    cyc();
    n_assert++;
    assert (o_ghr[4*EW-1:0] === {{EW{1'b0}}, ec, eb, ea ^ 33'h1}) else begin n_fail++; $error("FAIL ghr_flush: got %h expected %h", o_ghr[4*EW-1:0], {{EW{1'b0}}, ec, eb, ea ^ 33'h1}); end
    idle(); i_issueNum = 3;
    cyc();
    i_issueNum = 2; i_resolveNum = 1;
    cyc();
    n_assert++;
    assert (o_pendingB === 8'd4) else begin n_fail++; $error("FAIL pend_add: got %0d expected 4", o_pendingB); end
    i_issueNum = 9; i_resolveNum = 5; i_flush = 1'b1; i_flushDepth = 2;
    cyc();
    n_assert++;
    assert (o_pendingB === 8'd0) else begin n_fail++; $error("FAIL pend_flush: got %0d expected 0", o_pendingB); end
    idle(); i_issueNum = 255;
    cyc();
    i_issueNum = 1;
    cyc();
    n_assert++;
    assert (o_pendingB === 8'd255) else begin n_fail++; $error("FAIL pend_sat: got %0d expected 255", o_pendingB); end
    repeat (400) begin
      idle();
      i_issueNum = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 3));
      i_resolveNum = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 3));
      i_pushNum = PW'($urandom_range(0, 7));
      for (int j = 0; j < MP; j++) i_pushEntries[j*EW +: EW] = EW'({$urandom, $urandom});
      i_flush = ($urandom_range(0, 7) == 0);
      i_flushDepth = ($urandom_range(0, 7) == 0) ? FW'($urandom_range(0, 31)) : FW'($urandom_range(0, 3));
      i_trainValid = $urandom_range(0, 1) == 1;
      i_trainRow = RW'($urandom_range(0, 7));
      i_trainDir = WPR'($urandom);
      i_trainMask = WPR'($urandom);
      i_rdValid = $urandom_range(0, 1) == 1;
      i_rdRow = RW'($urandom_range(0, 7));
      cyc();
    end
    idle();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    repeat (100) cyc();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    repeat (ROWS - 1) cyc();
    n_assert++;
    assert (o_ready === 1'b0) else begin n_fail++; $error("FAIL reinit_early: got %b expected 0", o_ready); end
    cyc();
    n_assert++;
    assert (o_ready === 1'b1) else begin n_fail++; $error("FAIL reinit_len: got %b expected 1", o_ready); end
    i_rdValid = 1'b1; i_rdRow = 5;
    cyc();
    n_assert++;
    assert (o_rdWeights === '0) else begin n_fail++; $error("FAIL reinit_clear: got %h expected 0", o_rdWeights); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
